// File: rtl/adder_tx_pkg.sv
// Shared types and frame constants for the adder serial transmitter.
package adder_tx_pkg;

  localparam int unsigned FRAME_BITS = 11;
  localparam int unsigned DATA_BITS  = 9;
  localparam int unsigned BIT_CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

endpackage

// File: rtl/adder_bit_timer.sv
// N-cycle tick generator: counts 0..N-1 while enabled, ticks on the last count.
module adder_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick_c
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick_c = en && (cnt_q == LAST);
    cnt_d  = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick_c ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/adder_uart_tx.sv
// Captures a + b on a start strobe and sends it as start | sum[7:0] LSB first | carry | stop.
module adder_uart_tx
  import adder_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       start,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  tx_state_t              state_q, state_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic                   tx_q, tx_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   clr_c;
  logic                   tick_c;

  adder_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (clr_c),
    .en     (busy_q),
    .tick_c (tick_c)
  );

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    done_d    = 1'b0;
    clr_c     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && ena) begin
          state_d   = START;
          shreg_d   = DATA_BITS'(a) + DATA_BITS'(b);
          bit_cnt_d = '0;
          clr_c     = 1'b1;
        end
      end
      START: begin
        if (tick_c) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (tick_c) begin
          if (bit_cnt_q == BIT_CNT_W'(DATA_BITS - 1)) begin
            state_d = STOP;
          end else begin
            shreg_d   = shreg_q >> 1;
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          end
        end
      end
      STOP: begin
        if (tick_c) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level is registered from the next state so tx changes on the transition edge.
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_adder_uart_tx.sv
// Self-checking bench for adder_uart_tx: N=4 instance for framing/control, N=1 for back-to-back.
module tb_adder_uart_tx;

  localparam int N4 = 4;
  localparam int N1 = 1;

  logic       clk;
  logic       rst_n;
  logic       ena, start;
  logic [7:0] a, b;
  logic       tx, busy, done;
  logic       ena1, start1;
  logic [7:0] a1, b1;
  logic       tx1, busy1, done1;

  int checks = 0;
  int errors = 0;

  adder_uart_tx #(.CLKS_PER_BIT(N4)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start),
    .a(a), .b(b), .tx(tx), .busy(busy), .done(done)
  );

  adder_uart_tx #(.CLKS_PER_BIT(N1)) dut1 (
    .clk(clk), .rst_n(rst_n), .ena(ena1), .start(start1),
    .a(a1), .b(b1), .tx(tx1), .busy(busy1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: expected line level for each of the 11 bit periods.
  function automatic logic [10:0] frame_of(input logic [7:0] x, input logic [7:0] y);
    logic [31:0] s;
    logic [10:0] f;
    s = 32'(x) + 32'(y);
    f[0] = 1'b0;
    for (int i = 0; i < 9; i++) f[i+1] = s[i];
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; ena = 1'b1; start1 = 1'b1; ena1 = 1'b1;
    a = 8'($urandom); b = 8'($urandom); a1 = 8'($urandom); b1 = 8'($urandom);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({tx, busy, done, tx1, busy1, done1} !== 6'b100_100) begin
        errors++;
        $display("FAIL reset c%0d: got %b want 100100", c, {tx, busy, done, tx1, busy1, done1});
      end
    end
    start = 1'b0; start1 = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({tx, busy, done, tx1, busy1, done1} !== 6'b100_100) begin
      errors++;
      $display("FAIL reset_release: got %b want 100100", {tx, busy, done, tx1, busy1, done1});
    end
  endtask

  task automatic test_frames();
    logic [7:0]  va [0:6];
    logic [7:0]  vb [0:6];
    logic [10:0] exp;
    va[0] = 8'hC8; vb[0] = 8'h64;
    va[1] = 8'hFF; vb[1] = 8'hFF;
    va[2] = 8'h00; vb[2] = 8'h00;
    for (int v = 3; v < 7; v++) begin
      va[v] = 8'($urandom); vb[v] = 8'($urandom);
    end
    for (int v = 0; v < 7; v++) begin
      @(negedge clk);
      a = va[v]; b = vb[v]; ena = 1'b1; start = 1'b1;
      exp = frame_of(va[v], vb[v]);
      @(negedge clk);
      start = 1'b0;
      for (int j = 0; j < 11 * N4; j++) begin
        checks++;
        if ({tx, busy, done} !== {exp[j / N4], 2'b10}) begin
          errors++;
          $display("FAIL frame v%0d cyc%0d: got %b want %b", v, j, {tx, busy, done}, {exp[j / N4], 2'b10});
        end
        a = 8'($urandom); b = 8'($urandom);
        @(negedge clk);
      end
      checks++;
      if ({tx, busy, done} !== 3'b101) begin
        errors++;
        $display("FAIL frame_end v%0d: got %b want 101", v, {tx, busy, done});
      end
      @(negedge clk);
      checks++;
      if ({tx, busy, done} !== 3'b100) begin
        errors++;
        $display("FAIL done_width v%0d: got %b want 100", v, {tx, busy, done});
      end
    end
  endtask

  task automatic test_ignored_start();
    logic [10:0] exp;
    logic [2:0]  want;
    int          dones;
    @(negedge clk);
    a = 8'($urandom); b = 8'($urandom); ena = 1'b1; start = 1'b1;
    exp = frame_of(a, b);
    dones = 0;
    @(negedge clk);
    start = 1'b0;
    for (int j = 0; j < 13 * N4; j++) begin
      if (j < 11 * N4)       want = {exp[j / N4], 2'b10};
      else if (j == 11 * N4) want = 3'b101;
      else                   want = 3'b100;
      checks++;
      if ({tx, busy, done} !== want) begin
        errors++;
        $display("FAIL ignored_start cyc%0d: got %b want %b", j, {tx, busy, done}, want);
      end
      if (done === 1'b1) dones++;
      start = (j == 3 * N4) || (j == 7 * N4);
      ena   = !((j >= 5 * N4) && (j < 9 * N4));
      a = 8'($urandom); b = 8'($urandom);
      @(negedge clk);
    end
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL done_count: got %0d want 1", dones);
    end
  endtask

  task automatic test_ena_block();
    @(negedge clk);
    ena = 1'b0; start = 1'b1;
    for (int c = 0; c < 3 * N4; c++) begin
      @(negedge clk);
      checks++;
      if ({tx, busy, done} !== 3'b100) begin
        errors++;
        $display("FAIL ena_block c%0d: got %b want 100", c, {tx, busy, done});
      end
    end
    start = 1'b0; ena = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [7:0]  la, lb;
    logic [10:0] exp;
    @(negedge clk);
    a1 = 8'($urandom); b1 = 8'($urandom); ena1 = 1'b1; start1 = 1'b1;
    la = a1; lb = b1;
    for (int f = 0; f < 5; f++) begin
      exp = frame_of(la, lb);
      for (int p = 0; p < 11; p++) begin
        @(negedge clk);
        checks++;
        if ({tx1, busy1, done1} !== {exp[p], 2'b10}) begin
          errors++;
          $display("FAIL b2b f%0d bit%0d: got %b want %b", f, p, {tx1, busy1, done1}, {exp[p], 2'b10});
        end
        a1 = 8'($urandom); b1 = 8'($urandom);
      end
      @(negedge clk);
      checks++;
      if ({tx1, busy1, done1} !== 3'b101) begin
        errors++;
        $display("FAIL b2b_gap f%0d: got %b want 101", f, {tx1, busy1, done1});
      end
      a1 = 8'($urandom); b1 = 8'($urandom);
      la = a1; lb = b1;
    end
    start1 = 1'b0;
    repeat (14) @(negedge clk);
    checks++;
    if ({tx1, busy1, done1} !== 3'b100) begin
      errors++;
      $display("FAIL b2b_idle: got %b want 100", {tx1, busy1, done1});
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    a = 8'h00; b = 8'h00; ena = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5 * N4 + 1) @(negedge clk);
    checks++;
    if ({tx, busy} !== 2'b01) begin
      errors++;
      $display("FAIL pre_reset: got %b want 01", {tx, busy});
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({tx, busy, done} !== 3'b100) begin
      errors++;
      $display("FAIL async_reset: got %b want 100", {tx, busy, done});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 12 * N4; c++) begin
      @(negedge clk);
      checks++;
      if ({tx, busy, done} !== 3'b100) begin
        errors++;
        $display("FAIL post_reset c%0d: got %b want 100", c, {tx, busy, done});
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b0; start = 1'b0; a = '0; b = '0;
    ena1 = 1'b0; start1 = 1'b0; a1 = '0; b1 = '0;
    test_reset();
    test_frames();
    test_ignored_start();
    test_ena_block();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
